// File: rtl/arcade_input_cond.sv
// Player-control conditioning for the ScooterShooter core: synchronise, debounce,
// shape coin presses into fixed-width active-low pulses, and freeze timing while paused.
module arcade_input_cond #(
    parameter int unsigned N_BTN     = 16,
    parameter int unsigned CLK_DIV   = 49152,
    parameter int unsigned DEB_MS    = 4,
    parameter int unsigned COIN_MS   = 50,
    parameter int unsigned GAP_MS    = 100,
    parameter logic [15:0] COUNT_RST = 16'h0000
) (
    input  logic             clk_49m,
    input  logic             reset,
    input  logic [N_BTN-1:0] btn_in,
    input  logic [1:0]       coin_in,
    input  logic             pause,
    output logic [N_BTN-1:0] btn_out,
    output logic [1:0]       coin_out,
    output logic [15:0]      coin_count,
    output logic             tick
);

    localparam int unsigned NB   = N_BTN + 2;
    localparam int unsigned PW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned DW   = (DEB_MS > 1) ? $clog2(DEB_MS + 1) : 1;
    localparam int unsigned TMAX = (COIN_MS > GAP_MS) ? COIN_MS : GAP_MS;
    localparam int unsigned TW   = $clog2(TMAX + 1);

    typedef enum logic [1:0] {
        C_IDLE,
        C_PULSE,
        C_GAP
    } coin_state_t;

    logic [PW-1:0] pre_cnt;
    logic          tick_w;
    logic [NB-1:0] sync1;
    logic [NB-1:0] sync2;
    logic [NB-1:0] stable;
    logic [DW-1:0] deb_cnt [NB];
    logic [1:0]    coin_stab;
    logic [1:0]    coin_sync;
    logic [1:0]    coin_prev;
    logic [1:0]    coin_arm;
    logic [1:0]    coin_acc;
    coin_state_t   coin_st  [2];
    logic [TW-1:0] coin_tmr [2];

    assign tick_w    = !pause && (pre_cnt == PW'(CLK_DIV - 1));
    assign tick      = tick_w;
    assign coin_stab = stable[NB-1:N_BTN];
    assign coin_sync = sync2[NB-1:N_BTN];

    always_ff @(posedge clk_49m or negedge reset) begin
        if (!reset) begin
            pre_cnt <= '0;
        end else if (!pause) begin
            pre_cnt <= tick_w ? '0 : pre_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk_49m or negedge reset) begin
        if (!reset) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= {coin_in, btn_in};
            sync2 <= sync1;
        end
    end

    always_ff @(posedge clk_49m or negedge reset) begin
        if (!reset) begin
            stable <= '0;
            for (int unsigned i = 0; i < NB; i++) begin
                deb_cnt[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < NB; i++) begin
                if (sync2[i] == stable[i]) begin
                    deb_cnt[i] <= '0;
                end else if (tick_w) begin
                    if (deb_cnt[i] == DW'(DEB_MS - 1)) begin
                        stable[i]  <= sync2[i];
                        deb_cnt[i] <= '0;
                    end else begin
                        deb_cnt[i] <= deb_cnt[i] + 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk_49m or negedge reset) begin
        if (!reset) begin
            btn_out <= '1;
        end else begin
            btn_out <= ~stable[N_BTN-1:0];
        end
    end

    always_comb begin
        coin_acc = '0;
        for (int unsigned i = 0; i < 2; i++) begin
            coin_acc[i] = (coin_st[i] == C_IDLE) && coin_arm[i] && coin_stab[i] && !coin_prev[i];
        end
    end

    // A slot is armed only after its switch is seen open on a tick, so a coin
    // still held through reset cannot register as a fresh press.
    always_ff @(posedge clk_49m or negedge reset) begin
        if (!reset) begin
            coin_prev  <= '0;
            coin_arm   <= '0;
            coin_out   <= '1;
            coin_count <= COUNT_RST;
            for (int unsigned i = 0; i < 2; i++) begin
                coin_st[i]  <= C_IDLE;
                coin_tmr[i] <= '0;
            end
        end else begin
            coin_prev  <= coin_stab;
            coin_count <= coin_count + 16'(coin_acc[0]) + 16'(coin_acc[1]);
            for (int unsigned i = 0; i < 2; i++) begin
                if (tick_w && !coin_sync[i] && !coin_stab[i]) begin
                    coin_arm[i] <= 1'b1;
                end
                case (coin_st[i])
                    C_IDLE: begin
                        if (coin_acc[i]) begin
                            coin_st[i]  <= C_PULSE;
                            coin_tmr[i] <= '0;
                            coin_out[i] <= 1'b0;
                        end
                    end
                    C_PULSE: begin
                        if (coin_tmr[i] == TW'(COIN_MS)) begin
                            coin_st[i]  <= C_GAP;
                            coin_tmr[i] <= '0;
                            coin_out[i] <= 1'b1;
                        end else if (tick_w) begin
                            coin_tmr[i] <= coin_tmr[i] + 1'b1;
                        end
                    end
                    C_GAP: begin
                        if (coin_tmr[i] == TW'(GAP_MS)) begin
                            coin_st[i]  <= C_IDLE;
                            coin_tmr[i] <= '0;
                        end else if (tick_w) begin
                            coin_tmr[i] <= coin_tmr[i] + 1'b1;
                        end
                    end
                    default: begin
                        coin_st[i]  <= C_IDLE;
                        coin_tmr[i] <= '0;
                        coin_out[i] <= 1'b1;
                    end
                endcase
            end
        end
    end

endmodule
